// File: rtl/wormhole_rr_arbiter.sv
// Round-robin output-channel arbiter with wormhole grant locking.
// One output port is shared by IN_N inputs. A grant is taken on a head
// request and held until the tail flit is accepted. A flit-count
// watchdog forces a release when a packet runs past MAX_LEN flits.
module wormhole_rr_arbiter #(
  parameter int IN_N    = 5,
  parameter int MAX_LEN = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [IN_N-1:0] req_i,
  input  logic [IN_N-1:0] tail_i,
  input  logic            xfer_i,
  output logic [IN_N-1:0] grant_o,
  output logic            busy_o,
  output logic            err_o
);

  localparam int PTR_W   = (IN_N > 1) ? $clog2(IN_N) : 1;
  localparam int CNT_RAW = $clog2(MAX_LEN + 1);
  localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;

  localparam logic [PTR_W-1:0] PTR_RST    = PTR_W'(IN_N - 1);
  localparam logic [CNT_W-1:0] LIMIT_LAST = CNT_W'((MAX_LEN > 0) ? (MAX_LEN - 1) : 0);
  localparam bit               WDOG_ON    = (MAX_LEN != 0);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  ptr_next;
  logic [PTR_W-1:0]  gidx;
  logic [PTR_W-1:0]  gidx_next;
  logic [IN_N-1:0]   gnt;
  logic [IN_N-1:0]   gnt_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              err;
  logic              err_next;

  logic [PTR_W-1:0]  win_idx;
  logic              win_found;
  logic [PTR_W-1:0]  cand_idx;
  int                cand;

  logic              tail_hit;
  logic              limit_hit;
  logic              release_now;

  // Scan requests from ptr downwards with wrap; the first set request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < IN_N; k++) begin
      cand     = (int'(ptr) - k + IN_N) % IN_N;
      cand_idx = PTR_W'(cand);
      if (!win_found && req_i[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // A locked packet ends on an accepted tail from the owner or on the
  // accepted flit that reaches the watchdog limit; the tail takes precedence.
  always_comb begin
    tail_hit    = |(tail_i & gnt);
    limit_hit   = WDOG_ON && (cnt == LIMIT_LAST);
    release_now = (state == LOCKED) && xfer_i && (tail_hit || limit_hit);
  end

  // State register: IDLE or LOCKED, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: lock on any request, unlock on a release.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (win_found) state_next = LOCKED;
      LOCKED:  if (release_now) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of grant, pointer, flit counter and error pulse.
  always_comb begin
    gnt_next  = gnt;
    gidx_next = gidx;
    ptr_next  = ptr;
    cnt_next  = cnt;
    err_next  = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          gnt_next  = IN_N'(1) << win_idx;
          gidx_next = win_idx;
          cnt_next  = '0;
        end
      end
      LOCKED: begin
        if (release_now) begin
          gnt_next = '0;
          ptr_next = (gidx == '0) ? PTR_RST : (gidx - PTR_W'(1));
          cnt_next = '0;
          err_next = !tail_hit;
        end else if (xfer_i) begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        gnt_next = '0;
      end
    endcase
  end

  // Datapath registers; reset drops any grant immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gnt  <= '0;
      gidx <= '0;
      ptr  <= PTR_RST;
      cnt  <= '0;
      err  <= 1'b0;
    end else begin
      gnt  <= gnt_next;
      gidx <= gidx_next;
      ptr  <= ptr_next;
      cnt  <= cnt_next;
      err  <= err_next;
    end
  end

  // Outputs are plain decodes of registered state.
  always_comb begin
    grant_o = gnt;
    busy_o  = (state == LOCKED);
    err_o   = err;
  end

endmodule

// File: tb/tb_wormhole_rr_arbiter.sv
// Self-checking bench for wormhole_rr_arbiter: directed scenarios plus
// randomized traffic, all compared against a queue-based priority model.
module tb_wormhole_rr_arbiter;

  localparam int IN_N    = 5;
  localparam int MAX_LEN = 4;

  logic            clk_i;
  logic            rst_i;
  logic [IN_N-1:0] req_i;
  logic [IN_N-1:0] tail_i;
  logic            xfer_i;
  logic [IN_N-1:0] grant_o;
  logic            busy_o;
  logic            err_o;

  int checks;
  int errors;

  // Reference model: priority list (highest first), current owner, flit count.
  int prio[$];
  int owner;
  int flits;
  bit err_exp;

  wormhole_rr_arbiter #(
    .IN_N    (IN_N),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (req_i),
    .tail_i  (tail_i),
    .xfer_i  (xfer_i),
    .grant_o (grant_o),
    .busy_o  (busy_o),
    .err_o   (err_o)
  );

  // Free-running clock, period 10.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Compare one observed value with its expectation and count the result.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    prio.delete();
    for (int i = IN_N - 1; i >= 0; i--) prio.push_back(i);
    owner   = -1;
    flits   = 0;
    err_exp = 1'b0;
  endtask

  // Served input moves to the tail of the priority list.
  task automatic modelRelease(input bit forced);
    while (prio[$] != owner) prio.push_back(prio.pop_front());
    owner   = -1;
    flits   = 0;
    err_exp = forced;
  endtask

  // Predict the outputs after the next rising edge from the current inputs.
  task automatic modelStep();
    bit found;
    err_exp = 1'b0;
    if (owner < 0) begin
      found = 1'b0;
      foreach (prio[i]) begin
        if (!found && req_i[prio[i]]) begin
          found = 1'b1;
          owner = prio[i];
          flits = 0;
        end
      end
    end else if (xfer_i) begin
      flits++;
      if (tail_i[owner]) modelRelease(1'b0);
      else if (MAX_LEN != 0 && flits == MAX_LEN) modelRelease(1'b1);
    end
  endtask

  task automatic checkModel();
    logic [IN_N-1:0] g;
    g = '0;
    if (owner >= 0) g[owner] = 1'b1;
    checkOutput("grant", 32'(grant_o), 32'(g));
    checkOutput("busy", 32'(busy_o), 32'(owner >= 0));
    checkOutput("err", 32'(err_o), 32'(err_exp));
  endtask

  // On a falling edge: check current outputs, then drive the next inputs.
  task automatic applyStimulus(input logic [IN_N-1:0] req, input logic [IN_N-1:0] tail, input logic xfer);
    @(negedge clk_i);
    checkModel();
    req_i  = req;
    tail_i = tail;
    xfer_i = xfer;
    modelStep();
  endtask

  task automatic doReset();
    @(negedge clk_i);
    rst_i  = 1'b1;
    req_i  = '0;
    tail_i = '0;
    xfer_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    modelReset();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_i  = 1'b1;
    req_i  = '0;
    tail_i = '0;
    xfer_i = 1'b0;
    modelReset();
    doReset();

    // Reset state and basic arbitration with a three-flit packet.
    applyStimulus(5'b00000, 5'b00000, 1'b0);
    checkOutput("rst_grant", 32'(grant_o), 32'h0);
    checkOutput("rst_busy", 32'(busy_o), 32'h0);
    checkOutput("rst_err", 32'(err_o), 32'h0);
    applyStimulus(5'b10110, 5'b00000, 1'b0);
    applyStimulus(5'b10110, 5'b00000, 1'b1);
    checkOutput("first_grant", 32'(grant_o), 32'h10);
    checkOutput("first_busy", 32'(busy_o), 32'h1);
    applyStimulus(5'b10110, 5'b00000, 1'b1);
    applyStimulus(5'b10110, 5'b10000, 1'b1);
    applyStimulus(5'b10110, 5'b00000, 1'b0);
    checkOutput("bubble_grant", 32'(grant_o), 32'h0);
    applyStimulus(5'b10110, 5'b00000, 1'b0);
    checkOutput("second_grant", 32'(grant_o), 32'h04);
    applyStimulus(5'b00000, 5'b00100, 1'b1);
    applyStimulus(5'b00000, 5'b00000, 1'b0);

    // Fairness with single-flit packets from every input.
    doReset();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(5'b11111, 5'b11111, 1'b1);
      if (i % 2 == 1) checkOutput("fair_grant", 32'(grant_o), 32'(1) << (4 - ((i / 2) % 5)));
      else            checkOutput("fair_gap", 32'(grant_o), 32'h0);
    end

    // Grant holds while the owner drops its request and another input asks.
    doReset();
    applyStimulus(5'b00010, 5'b00000, 1'b0);
    applyStimulus(5'b01000, 5'b01000, 1'b1);
    checkOutput("hold_a", 32'(grant_o), 32'h02);
    applyStimulus(5'b01000, 5'b00000, 1'b1);
    checkOutput("hold_b", 32'(grant_o), 32'h02);
    applyStimulus(5'b01000, 5'b00010, 1'b1);
    checkOutput("hold_c", 32'(grant_o), 32'h02);
    applyStimulus(5'b01000, 5'b00000, 1'b0);
    checkOutput("hold_release", 32'(grant_o), 32'h0);
    applyStimulus(5'b00000, 5'b01000, 1'b1);
    checkOutput("hold_next", 32'(grant_o), 32'h08);
    applyStimulus(5'b00000, 5'b00000, 1'b0);

    // Watchdog: four flits without a tail, then four with a tail on the last.
    doReset();
    applyStimulus(5'b00001, 5'b00000, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(5'b00000, 5'b00000, 1'b1);
    applyStimulus(5'b00000, 5'b00000, 1'b0);
    checkOutput("wd_grant", 32'(grant_o), 32'h0);
    checkOutput("wd_err", 32'(err_o), 32'h1);
    applyStimulus(5'b00001, 5'b00000, 1'b0);
    checkOutput("wd_err_clear", 32'(err_o), 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus(5'b00000, 5'b00000, 1'b1);
    applyStimulus(5'b00000, 5'b00001, 1'b1);
    applyStimulus(5'b00000, 5'b00000, 1'b0);
    checkOutput("wd_tail_grant", 32'(grant_o), 32'h0);
    checkOutput("wd_tail_err", 32'(err_o), 32'h0);

    // Idle with stray xfer/tail pulses leaves the pointer untouched.
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(5'b00000, 5'(i + 7), 1'(i % 2));
    applyStimulus(5'b11111, 5'b00000, 1'b0);
    checkOutput("idle_busy", 32'(busy_o), 32'h0);
    applyStimulus(5'b11111, 5'b00000, 1'b0);
    checkOutput("idle_then_grant", 32'(grant_o), 32'h10);

    // Asynchronous reset while locked on input 2.
    doReset();
    applyStimulus(5'b00100, 5'b00000, 1'b0);
    applyStimulus(5'b00100, 5'b00000, 1'b1);
    checkOutput("pre_rst_grant", 32'(grant_o), 32'h04);
    #1;
    rst_i = 1'b1;
    #1;
    checkOutput("async_rst_grant", 32'(grant_o), 32'h0);
    checkOutput("async_rst_busy", 32'(busy_o), 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    req_i = '0;
    tail_i = '0;
    xfer_i = 1'b0;
    modelReset();
    applyStimulus(5'b11111, 5'b00000, 1'b0);
    applyStimulus(5'b00000, 5'b10000, 1'b1);
    checkOutput("post_rst_grant", 32'(grant_o), 32'h10);
    applyStimulus(5'b00000, 5'b00000, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(5'($urandom), ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0,
                    1'($urandom_range(0, 3) != 0));
    end
    applyStimulus(5'b00000, 5'b00000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
